// File: rtl/hex_display_scheduler_pkg.sv
// Shared definitions for the hex display scheduler.
//   state_e          : scheduler FSM states (idle, nibble scan, commit)
//   NumDigitsDefault : default number of 7-segment digits served
//   BlankSeg         : active-low pattern that leaves a digit dark
//   idx_width()      : width of a digit index for a given digit count
package hex_display_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StScan   = 2'd1,
        StCommit = 2'd2
    } state_e;

    localparam int unsigned NumDigitsDefault = 6;
    localparam logic [6:0]  BlankSeg         = 7'h7F;

    // A single-digit build still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/hex_display_scheduler_if.sv
// Bundle of request, decoder and display signals around the hex display scheduler.
//   load, value, lz_en : display request from the CPU/debug datapath
//   dec_x, dec_z       : nibble out to / active-low pattern back from the shared decoder
//   hex_out            : committed active-low patterns, digit i = hex_out[7i+6:7i]
//   busy, done         : scheduler status (done pulses once per commit)
// modport slave  : the scheduler itself
// modport master : the surroundings (requester, shared decoder, display consumer)
interface hex_display_scheduler_if
    import hex_display_scheduler_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NumDigitsDefault
) ();

    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      lz_en;
    logic [3:0]                dec_x;
    logic [6:0]                dec_z;
    logic [7*NUM_DIGITS-1:0]   hex_out;
    logic                      busy;
    logic                      done;

    modport slave (
        input  load,
        input  value,
        input  lz_en,
        input  dec_z,
        output dec_x,
        output hex_out,
        output busy,
        output done
    );

    modport master (
        output load,
        output value,
        output lz_en,
        output dec_z,
        input  dec_x,
        input  hex_out,
        input  busy,
        input  done
    );

endinterface

// File: rtl/hex_display_scheduler.sv
// Time-multiplexes one external hex-to-7-segment decoder across NUM_DIGITS displays.
// A load captures a packed hex value; the scan walks the nibbles from the most
// significant down, storing each decoded pattern (or a blank for suppressed leading
// zeros) in a shadow register. All digits are then committed to hex_out in one cycle.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of hex_display_scheduler_if (load/value/lz_en request,
//           dec_x/dec_z decoder loop, hex_out/busy/done outputs)
module hex_display_scheduler
    import hex_display_scheduler_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NumDigitsDefault,
    parameter logic [6:0]  BLANK_SEG  = BlankSeg
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_display_scheduler_if.slave  bus
);

    localparam int unsigned          IdxW    = idx_width(NUM_DIGITS);
    localparam logic [IdxW-1:0]      LastIdx = IdxW'(NUM_DIGITS - 1);
    localparam int unsigned          ValW    = 4 * NUM_DIGITS;

    state_e                          state_q, state_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic                            suppress_q, suppress_d;
    logic [ValW-1:0]                 job_q, job_d;
    logic                            pend_q, pend_d;
    logic [ValW-1:0]                 pend_value_q, pend_value_d;
    logic                            pend_lz_q, pend_lz_d;
    logic [NUM_DIGITS-1:0][6:0]      shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][6:0]      hex_q, hex_d;
    logic                            done_q, done_d;

    logic [3:0]                      cur_nib;
    logic                            blank_digit;
    logic [3:0]                      dec_x;

    assign cur_nib = job_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        suppress_d   = suppress_q;
        job_d        = job_q;
        pend_d       = pend_q;
        pend_value_d = pend_value_q;
        pend_lz_d    = pend_lz_q;
        shadow_d     = shadow_q;
        hex_d        = hex_q;
        done_d       = 1'b0;
        dec_x        = 4'h0;
        blank_digit  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.load) begin
                    job_d      = bus.value;
                    suppress_d = bus.lz_en;
                    idx_d      = LastIdx;
                    state_d    = StScan;
                end
            end

            StScan: begin
                dec_x       = cur_nib;
                // Digit 0 always shows, so an all-zero value still reads "0".
                blank_digit = suppress_q && (cur_nib == 4'h0) && (idx_q != '0);
                shadow_d[idx_q] = blank_digit ? BLANK_SEG : bus.dec_z;
                if (cur_nib != 4'h0) begin
                    suppress_d = 1'b0;
                end
                if (idx_q == '0) begin
                    state_d = StCommit;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
                if (bus.load) begin
                    pend_d       = 1'b1;
                    pend_value_d = bus.value;
                    pend_lz_d    = bus.lz_en;
                end
            end

            StCommit: begin
                hex_d  = shadow_q;
                done_d = 1'b1;
                if (bus.load) begin
                    // A load at this edge is newer than anything pending, so it
                    // supersedes the pending job rather than queueing behind it.
                    job_d      = bus.value;
                    suppress_d = bus.lz_en;
                    idx_d      = LastIdx;
                    pend_d     = 1'b0;
                    state_d    = StScan;
                end else if (pend_q) begin
                    job_d      = pend_value_q;
                    suppress_d = pend_lz_q;
                    idx_d      = LastIdx;
                    pend_d     = 1'b0;
                    state_d    = StScan;
                end else begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            suppress_q   <= 1'b0;
            job_q        <= '0;
            pend_q       <= 1'b0;
            pend_value_q <= '0;
            pend_lz_q    <= 1'b0;
            shadow_q     <= {NUM_DIGITS{BLANK_SEG}};
            hex_q        <= {NUM_DIGITS{BLANK_SEG}};
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            suppress_q   <= suppress_d;
            job_q        <= job_d;
            pend_q       <= pend_d;
            pend_value_q <= pend_value_d;
            pend_lz_q    <= pend_lz_d;
            shadow_q     <= shadow_d;
            hex_q        <= hex_d;
            done_q       <= done_d;
        end
    end

    assign bus.dec_x   = dec_x;
    assign bus.hex_out = hex_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench for hex_display_scheduler: directed loads with literal
// expectations plus a transaction-level reference model compared every cycle.
module tb_hex_display_scheduler;
    import hex_display_scheduler_pkg::*;

    localparam int N = 6;

    localparam logic [41:0] ExpBlank   = {6{7'h7F}};
    localparam logic [41:0] ExpA5F3Lz  = {7'h7F, 7'h7F, 7'h08, 7'h12, 7'h0E, 7'h30};
    localparam logic [41:0] ExpA5F3    = {7'h40, 7'h40, 7'h08, 7'h12, 7'h0E, 7'h30};
    localparam logic [41:0] ExpZeroLz  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [41:0] Exp888888  = 42'h0;
    localparam logic [41:0] Exp123456  = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [41:0] Exp000001  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79};

    logic clk = 1'b0;
    logic reset;

    hex_display_scheduler_if #(.NUM_DIGITS(N)) bus ();

    hex_display_scheduler #(
        .NUM_DIGITS (N),
        .BLANK_SEG  (7'h7F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Standard active-low hex decoder (segment order g..a).
    function automatic logic [6:0] seg7(input logic [3:0] x);
        case (x)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_comb bus.dec_z = seg7(bus.dec_x);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // What a display of value v looks like: leading zeros dark when lz is set,
    // except the units digit.
    function automatic logic [41:0] render(input logic [23:0] v, input logic lz);
        logic [41:0] r;
        logic        leading;
        logic [3:0]  nib;
        leading = lz;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            nib = v[4*i +: 4];
            if (leading && nib == 4'h0 && i != 0) begin
                r[7*i +: 7] = 7'h7F;
            end else begin
                r[7*i +: 7] = seg7(nib);
                leading = 1'b0;
            end
        end
        return r;
    endfunction

    // A job occupies N scan cycles then one commit cycle.
    bit          m_active;
    int          m_count;
    logic [23:0] m_val;
    logic        m_lz;
    bit          p_valid;
    logic [23:0] p_val;
    logic        p_lz;
    logic [41:0] m_hex;
    bit          m_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 0;
            m_count  = 0;
            p_valid  = 0;
            m_hex    = ExpBlank;
            m_done   = 0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (bus.load) begin
                    m_active = 1; m_count = 0; m_val = bus.value; m_lz = bus.lz_en;
                end
            end else if (m_count < N) begin
                if (bus.load) begin
                    p_valid = 1; p_val = bus.value; p_lz = bus.lz_en;
                end
                m_count++;
            end else begin
                m_hex  = render(m_val, m_lz);
                m_done = 1;
                if (bus.load) begin
                    m_count = 0; m_val = bus.value; m_lz = bus.lz_en; p_valid = 0;
                end else if (p_valid) begin
                    m_count = 0; m_val = p_val; m_lz = p_lz; p_valid = 0;
                end else begin
                    m_active = 0;
                end
            end
        end
    end

    function automatic logic [3:0] exp_dec_x();
        if (m_active && m_count < N) begin
            return m_val[4*(N-1-m_count) +: 4];
        end
        return 4'h0;
    endfunction

    always @(negedge clk) begin
        check("hex_out", 64'(bus.hex_out), 64'(m_hex));
        check("busy", 64'(bus.busy), 64'(m_active));
        check("done", 64'(bus.done), 64'(m_done));
        check("dec_x", 64'(bus.dec_x), 64'(exp_dec_x()));
    end

    // ---------------- stimulus ----------------
    task automatic start_load(input logic [23:0] v, input logic lz);
        @(posedge clk);
        #2;
        bus.load  = 1'b1;
        bus.value = v;
        bus.lz_en = lz;
        @(posedge clk);
        #2;
        bus.load  = 1'b0;
        bus.value = ~v;     // must not disturb the job in flight
        bus.lz_en = ~lz;
    endtask

    task automatic wait_done(input string name, output int cyc, output int bz);
        bit seen;
        cyc  = 0;
        bz   = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) bz++;
            if (bus.done) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done pulse, expected one within 40 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int bz;
        int done_cyc[$];
        logic [41:0] done_hex[$];

        reset     = 1'b1;
        bus.load  = 1'b0;
        bus.value = '0;
        bus.lz_en = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hex", 64'(bus.hex_out), 64'(ExpBlank));
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // A5F3 with leading-zero blanking
        start_load(24'h00A5F3, 1'b1);
        wait_done("a", cyc, bz);
        check("a_latency", 64'(cyc), 64'd8);
        check("a_busy_cycles", 64'(bz), 64'd7);
        check("a_hex", 64'(bus.hex_out), 64'(ExpA5F3Lz));
        check("a_model", 64'(m_hex), 64'(ExpA5F3Lz));

        // Same value, zeros shown
        start_load(24'h00A5F3, 1'b0);
        wait_done("b", cyc, bz);
        check("b_busy_cycles", 64'(bz), 64'd7);
        check("b_hex", 64'(bus.hex_out), 64'(ExpA5F3));

        // All zeros: only the units digit lights
        start_load(24'h000000, 1'b1);
        wait_done("c0", cyc, bz);
        check("c0_hex", 64'(bus.hex_out), 64'(ExpZeroLz));
        check("c0_model", 64'(m_hex), 64'(ExpZeroLz));
        start_load(24'h888888, 1'b1);
        wait_done("c8", cyc, bz);
        check("c8_hex", 64'(bus.hex_out), 64'(Exp888888));

        // Loads during the scan: newest pending wins, no idle gap
        start_load(24'h123456, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cyc.push_back(c);
                done_hex.push_back(bus.hex_out);
            end
            if (c == 2) begin
                bus.load = 1'b1; bus.value = 24'hABCDEF; bus.lz_en = 1'b0;
            end else if (c == 3) begin
                bus.value = 24'h000001;
            end else if (c == 4) begin
                bus.load = 1'b0; bus.value = 24'h777777;
            end
        end
        check("d_done_count", 64'(done_cyc.size()), 64'd2);
        if (done_cyc.size() == 2) begin
            check("d_first_cycle", 64'(done_cyc[0]), 64'd8);
            check("d_second_cycle", 64'(done_cyc[1]), 64'd15);
            check("d_first_hex", 64'(done_hex[0]), 64'(Exp123456));
            check("d_second_hex", 64'(done_hex[1]), 64'(Exp000001));
        end

        // Reset in the middle of a scan
        start_load(24'h888888, 1'b0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("e_reset_hex", 64'(bus.hex_out), 64'(ExpBlank));
        check("e_reset_busy", 64'(bus.busy), 64'd0);
        check("e_reset_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        bz = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) bz++;
        end
        check("e_no_done", 64'(bz), 64'd0);
        start_load(24'h00A5F3, 1'b1);
        wait_done("e", cyc, bz);
        check("e_latency", 64'(cyc), 64'd8);
        check("e_hex", 64'(bus.hex_out), 64'(ExpA5F3Lz));

        // load held high: a job every N+1 cycles
        done_cyc.delete();
        @(negedge clk);
        bus.load = 1'b1; bus.value = 24'h888888; bus.lz_en = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (bus.done) done_cyc.push_back(c);
            if (c == 10) begin
                bus.value = 24'h000100; bus.lz_en = 1'b1;
            end
        end
        bus.load = 1'b0;
        check("f_done_count", 64'(done_cyc.size()), 64'd3);
        if (done_cyc.size() == 3) begin
            check("f_first", 64'(done_cyc[0]), 64'd8);
            check("f_gap1", 64'(done_cyc[1] - done_cyc[0]), 64'd7);
            check("f_gap2", 64'(done_cyc[2] - done_cyc[1]), 64'd7);
        end
        repeat (20) @(negedge clk);
        check("f_idle", 64'(bus.busy), 64'd0);
        check("f_hex", 64'(bus.hex_out), 64'(render(24'h000100, 1'b1)));

        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
